window_7x7_sequencer: RTL and testbench

Frame-level sequencer for the 7x7 sliding-window datapath. It accepts the stream of 7-pixel columns delivered by the line buffers, one column per cycle when `valid_i` is high. From that stream it generates the shift enable for the window datapath and tracks the column and row-band counters. It flags windows that are fully populated and signals end-of-frame. It sits between the 7-row line-buffer stage and the 7x7 window buffer datapath, replacing ad-hoc threshold logic with one registered control point.

---
 rtl/window_7x7_pkg.sv | 19 +
 rtl/window_7x7_pos_counter.sv | 54 +++++
 rtl/window_7x7_sequencer.sv | 141 ++++++++++++++
 tb/tb_window_7x7_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/window_7x7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_7x7_pkg
// Brief    : Shared constants and state type for the 7x7 window sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package window_7x7_pkg;

    localparam int KSIZE       = 7;
    localparam int FILL_THRESH = KSIZE - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/window_7x7_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : window_7x7_pos_counter
// Brief    : Column / row-band counter pair with enable, clear, wrap at the
//            end of each row and a flag for the last column of the last band.
// Revision : 1.0 - initial release
// ============================================================================
module window_7x7_pos_counter #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      en,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   band,
    output logic                      last
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic col_end;
    logic band_end;

    // End-of-row and end-of-frame position decode
    always_comb begin
        col_end  = (col == CW'(COLS - 1));
        band_end = (band == RW'(ROWS - 7));
        last     = col_end && band_end;
    end

    // Advance column per enable; wrap into the next band at end of row
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            col  <= '0;
            band <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                if (band_end) begin
                    band <= '0;
                end else begin
                    band <= band + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_7x7_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : window_7x7_sequencer
// Brief    : Frame-level control for the 7x7 sliding-window datapath: shift
//            enable, window-valid flag with position, busy/done/progress.
//            Optional macro WINDOW_7X7_SEQ_BORDER_EN adds registered border
//            flags aligned with win_valid_o.
// Revision : 1.0 - initial release
// ============================================================================
module window_7x7_sequencer
    import window_7x7_pkg::*;
#(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      valid_i,
    output logic                      count_en_o,
    output logic                      win_valid_o,
    output logic [$clog2(ROWS)-1:0]   row_o,
    output logic [$clog2(COLS)-1:0]   col_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      progress_done_o
`ifdef WINDOW_7X7_SEQ_BORDER_EN
    ,
    output logic                      first_col_o,
    output logic                      last_col_o,
    output logic                      first_row_o,
    output logic                      last_row_o
`endif
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    generate
        if (COLS < KSIZE || ROWS < KSIZE) begin : g_param_check
            $error("window_7x7_sequencer: COLS and ROWS must both be 7 or more");
        end
    endgenerate

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              accept;
    logic              fill;
    logic              clr;
    logic              last;
    logic [CW-1:0]     col;
    logic [RW-1:0]     band;

    window_7x7_pos_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept),
        .col   (col),
        .band  (band),
        .last  (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start from IDLE, finish on the last accepted column
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)        state_nxt = RUN;
            RUN:     if (accept && last) state_nxt = DONE;
            DONE:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Combinational outputs and column-acceptance decode
    always_comb begin
        accept     = valid_i && (state == RUN);
        fill       = accept && (col >= CW'(FILL_THRESH));
        clr        = (state == IDLE) && start_i;
        count_en_o = accept;
        busy_o     = (state != IDLE);
        done_o     = (state == DONE);
    end

    // Window flag and position, one cycle behind the accepted column
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_o <= 1'b0;
            row_o       <= '0;
            col_o       <= '0;
        end else begin
            win_valid_o <= fill;
            if (fill) begin
                col_o <= col - CW'(FILL_THRESH);
                row_o <= band;
            end
        end
    end

    // Frame-complete level: set with the final column, cleared on a new frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            progress_done_o <= 1'b0;
        end else if (clr) begin
            progress_done_o <= 1'b0;
        end else if (accept && last) begin
            progress_done_o <= 1'b1;
        end
    end

`ifdef WINDOW_7X7_SEQ_BORDER_EN
    // Border flags aligned with win_valid_o; forced low when no window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_col_o <= 1'b0;
            last_col_o  <= 1'b0;
            first_row_o <= 1'b0;
            last_row_o  <= 1'b0;
        end else begin
            first_col_o <= fill && (col == CW'(FILL_THRESH));
            last_col_o  <= fill && (col == CW'(COLS - 1));
            first_row_o <= fill && (band == '0);
            last_row_o  <= fill && (band == RW'(ROWS - 7));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_7x7_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_7x7_sequencer
// Brief    : Self-checking bench for window_7x7_sequencer (COLS=10, ROWS=8)
//            using a frame-level reference model driven by accept counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_7x7_sequencer;

    localparam int COLS = 10;
    localparam int ROWS = 8;
    localparam int FRAME_ACCEPTS = COLS * (ROWS - 6);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start_i = 1'b0;
    logic                     valid_i = 1'b0;
    logic                     count_en_o;
    logic                     win_valid_o;
    logic [$clog2(ROWS)-1:0]  row_o;
    logic [$clog2(COLS)-1:0]  col_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     progress_done_o;
`ifdef WINDOW_7X7_SEQ_BORDER_EN
    logic                     first_col_o;
    logic                     last_col_o;
    logic                     first_row_o;
    logic                     last_row_o;
`endif

    window_7x7_sequencer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .valid_i         (valid_i),
        .count_en_o      (count_en_o),
        .win_valid_o     (win_valid_o),
        .row_o           (row_o),
        .col_o           (col_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .progress_done_o (progress_done_o)
`ifdef WINDOW_7X7_SEQ_BORDER_EN
        ,
        .first_col_o     (first_col_o),
        .last_col_o      (last_col_o),
        .first_row_o     (first_row_o),
        .last_row_o      (last_row_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level model: phase 0 idle, 1 collecting columns, 2 end-of-frame cycle
    int m_phase = 0;
    int m_k     = 0;
    int m_prog  = 0;
    int e_win   = 0;
    int e_row   = 0;
    int e_col   = 0;
    int win_seen  = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("win_valid", 32'(win_valid_o), 32'(e_win));
        if (e_win != 0) begin
            chk("row", 32'(row_o), 32'(e_row));
            chk("col", 32'(col_o), 32'(e_col));
        end
        chk("done", 32'(done_o), 32'(m_phase == 2));
        chk("busy", 32'(busy_o), 32'(m_phase != 0));
        chk("progress", 32'(progress_done_o), 32'(m_prog));
`ifdef WINDOW_7X7_SEQ_BORDER_EN
        chk("first_col", 32'(first_col_o), 32'(e_win != 0 && e_col == 0));
        chk("last_col",  32'(last_col_o),  32'(e_win != 0 && e_col == COLS - 7));
        chk("first_row", 32'(first_row_o), 32'(e_win != 0 && e_row == 0));
        chk("last_row",  32'(last_row_o),  32'(e_win != 0 && e_row == ROWS - 7));
`endif
        if (win_valid_o === 1'b1) win_seen++;
        if (done_o === 1'b1) done_seen++;
    endtask

    // One clock cycle with the given inputs, model advanced alongside
    task automatic step(input logic st, input logic vl);
        int nxt;
        @(negedge clk);
        rst_n   = 1'b1;
        start_i = st;
        valid_i = vl;
        #1;
        chk("count_en", 32'(count_en_o), 32'(vl && m_phase == 1));
        nxt   = m_phase;
        e_win = 0;
        case (m_phase)
            0: if (st) begin
                nxt    = 1;
                m_k    = 0;
                m_prog = 0;
            end
            1: if (vl) begin
                if ((m_k % COLS) >= 6) begin
                    e_win = 1;
                    e_col = (m_k % COLS) - 6;
                    e_row = m_k / COLS;
                end
                m_k++;
                if (m_k == FRAME_ACCEPTS) begin
                    nxt    = 2;
                    m_prog = 1;
                end
            end
            default: nxt = 0;
        endcase
        m_phase = nxt;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        m_phase = 0;
        m_k     = 0;
        m_prog  = 0;
        e_win   = 0;
        @(posedge clk);
        #1;
        check_outputs();
        chk("rst_row", 32'(row_o), 32'd0);
        chk("rst_col", 32'(col_o), 32'd0);
        chk("rst_count_en", 32'(count_en_o), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();

        // Valid while idle is ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Basic frame: start (with valid on the same cycle), 20 consecutive columns
        win_seen = 0; done_seen = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < FRAME_ACCEPTS; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("basic_windows", 32'(win_seen), 32'd8);
        chk("basic_done_pulses", 32'(done_seen), 32'd1);

        // Stalled frame with alternating valid and a mid-frame start
        win_seen = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME_ACCEPTS; i++)
            step(i == 9, (i % 2) == 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("stall_windows", 32'(win_seen), 32'd8);

        // Reset after 13 accepts, then a full frame
        step(1'b1, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
        do_reset();
        win_seen = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < FRAME_ACCEPTS; i++) step(1'b0, 1'b1);
        chk("post_reset_windows", 32'(win_seen), 32'd8);

        // Back-to-back: start in the cycle right after DONE
        step(1'b0, 1'b0);
        win_seen = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < FRAME_ACCEPTS; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("b2b_windows", 32'(win_seen), 32'd8);

        // Randomised frames with random gaps and stray starts
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 400 && m_phase != 0; i++)
                step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
            chk("rand_frame_ended", 32'(m_phase), 32'd0);
            for (int i = 0; i < 3; i++)
                step(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
